scanline_pingpong_ram: RTL and testbench
========================================

Name: scanline_pingpong_ram

Overview:
- Parametrised, double-banked scanline buffer between the tile/sprite fetch stage (two write ports) and the LCD pixel output stage (one registered read port).
- Fetchers fill the back bank while the LCD reads the front bank.
- A swap pulse exchanges the banks, then a clear sequencer zeroes the new back bank, so each line starts from zero without a bulk reset.

Parameters:
- DATA_W, 8, width of each entry.
- DEPTH, 20, entries per bank (one per 8-pixel tile column); must be at least 2.
- ADDR_W, 5, address width; must satisfy 2^ADDR_W >= DEPTH.

Ports:
- clk  in  1  system clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- wr_enA  in  1  write strobe, port A (background fetcher), back bank.
- wr_addrA  in  ADDR_W  port A write address.
- wr_dataA  in  DATA_W  port A write data.
- wr_enB  in  1  write strobe, port B (sprite fetcher), back bank.
- wr_addrB  in  ADDR_W  port B write address.
- wr_dataB  in  DATA_W  port B write data.
- rd_en  in  1  read strobe, front bank.
- rd_addr  in  ADDR_W  read address.
- rd_data  out  DATA_W  registered read data.
- rd_valid  out  1  high the cycle after an accepted read.
- swap  in  1  single-cycle request to exchange banks.
- front_bank  out  1  index of the bank currently being read.
- clr_busy  out  1  clear sequencer active; writes and swaps are refused.
- err  out  1  one-cycle pulse on any refused or out-of-range operation.

Behaviour:
- Storage: two banks of DEPTH x DATA_W. The back bank is the complement of front_bank. The memory array itself is not reset; it is cleared by the sequencer.
- Reset (rst=0, asynchronous):
  - front_bank=0, rd_data=0, rd_valid=0, err=0.
  - clr_busy=1, state=INIT, clr_cnt=0.
- FSM states:
  - INIT: after reset release, one entry per cycle at index clr_cnt is zeroed in BOTH banks. clr_cnt runs 0..DEPTH-1, so INIT lasts exactly DEPTH cycles. Then go to IDLE and drop clr_busy on that same edge.
  - IDLE: normal operation, clr_busy=0.
  - CLEAR: entered on an accepted swap. Zeroes the new back bank at index clr_cnt, 0..DEPTH-1, one entry per cycle. clr_busy=1 from the cycle after the swap edge for exactly DEPTH cycles, then return to IDLE.
- Writes:
  - Accepted only in IDLE with addr < DEPTH. Written into the back bank at the rising edge; no read-back on the write ports.
  - A and B at the same address in the same cycle: B's data is stored.
  - A write with addr >= DEPTH is dropped and err pulses for one cycle.
  - A write while clr_busy=1 is dropped and err pulses for one cycle.
- Reads:
  - rd_en sampled at edge N; rd_data/rd_valid update at edge N, visible in cycle N+1 (latency 1).
  - Data comes from the front bank as it stood before edge N.
  - rd_addr >= DEPTH returns 0 with rd_valid=1 and pulses err.
  - During INIT, rd_data is 0.
  - rd_en=0 drives rd_valid=0 and rd_data holds its last value.
- Swap:
  - Accepted only in IDLE. front_bank toggles at the swap edge and the FSM enters CLEAR.
  - Writes in the swap cycle land in the pre-swap back bank (the new front), so the finished line includes them.
  - A read in the swap cycle uses the pre-swap front bank.
  - Swap while clr_busy=1 is ignored and pulses err.
- err:
  - Single OR of all refusal and range conditions in a cycle; one pulse per cycle regardless of how many conditions hit.
- Reset mid-CLEAR or mid-INIT: returns immediately to the reset values; the INIT clear restarts from index 0.
- Counter width: clr_cnt is ADDR_W bits and compares against DEPTH-1; it never wraps past DEPTH-1.

Test Plan:
- Reset, release, count cycles -> clr_busy=1 for exactly 20 cycles, then 0. Reads of addr 0..19 then return 0x00 with rd_valid=1 one cycle after each rd_en.
- In IDLE, write A addr3=0x5A and B addr7=0xC3, swap, wait for clr_busy=0, read addr3 and addr7 -> rd_data 0x5A and 0xC3; front_bank=1.
- Same cycle wr_enA addr5=0x11 and wr_enB addr5=0x22, then swap and read addr5 -> 0x22.
- Write in the swap cycle addr9=0x77, then swap again after clearing and read addr9 from the old bank:
  - After the first swap, the read returns 0x77.
  - After the second swap completes, that bank has been cleared, so reading addr9 returns 0x00.
- During CLEAR, issue a write and a swap, plus a write with addr=20 and a read with addr=25 in IDLE:
  - Each produces a one-cycle err pulse and memory is unchanged.
  - The out-of-range read returns 0x00 with rd_valid=1.
- Assert rst at CLEAR cycle 10 -> all outputs return to their reset values at once, INIT restarts, and clr_busy stays high 20 cycles after release.

Source files
------------

// File: rtl/scanline_pingpong_ram.sv
// Double-banked scanline buffer: two fetch write ports fill the back bank while the
// LCD reads the front bank; a swap exchanges banks and a sequencer zeroes the new back bank.
module scanline_pingpong_ram #(
   parameter int unsigned DATA_W = 8,
   parameter int unsigned DEPTH  = 20,
   parameter int unsigned ADDR_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              wr_enA,
   input  logic [ADDR_W-1:0] wr_addrA,
   input  logic [DATA_W-1:0] wr_dataA,
   input  logic              wr_enB,
   input  logic [ADDR_W-1:0] wr_addrB,
   input  logic [DATA_W-1:0] wr_dataB,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   input  logic              swap,
   output logic              front_bank,
   output logic              clr_busy,
   output logic              err
);

   localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

   typedef enum logic [1:0] {INIT, IDLE, CLEAR} state_t;

   state_t            state, stateNext;
   logic [ADDR_W-1:0] clrCnt, clrCntNext;
   logic              frontNext, clrBusyNext, errNext, rdValidNext;
   logic [DATA_W-1:0] rdDataNext;
   logic              wrAOk, wrBOk, clrBank0, clrBank1;
   logic              inRangeA, inRangeB, inRangeRd, isIdle;

   logic [DATA_W-1:0] mem [2][DEPTH];

   assign inRangeA  = 32'(wr_addrA) < DEPTH;
   assign inRangeB  = 32'(wr_addrB) < DEPTH;
   assign inRangeRd = 32'(rd_addr) < DEPTH;
   assign isIdle    = (state == IDLE);

   // Next-state, port acceptance and registered-output next values
   always_comb begin
      stateNext   = state;
      clrCntNext  = clrCnt;
      frontNext   = front_bank;
      wrAOk       = 1'b0;
      wrBOk       = 1'b0;
      clrBank0    = 1'b0;
      clrBank1    = 1'b0;
      rdValidNext = rd_en;
      rdDataNext  = rd_data;

      case (state)
         INIT: begin
            clrBank0 = 1'b1;
            clrBank1 = 1'b1;
            if (clrCnt == LAST_IDX) begin
               stateNext  = IDLE;
               clrCntNext = '0;
            end else begin
               clrCntNext = clrCnt + ADDR_W'(1);
            end
         end
         CLEAR: begin
            clrBank0 = front_bank;
            clrBank1 = ~front_bank;
            if (clrCnt == LAST_IDX) begin
               stateNext  = IDLE;
               clrCntNext = '0;
            end else begin
               clrCntNext = clrCnt + ADDR_W'(1);
            end
         end
         IDLE: begin
            wrAOk = wr_enA & inRangeA;
            wrBOk = wr_enB & inRangeB;
            if (swap) begin
               frontNext  = ~front_bank;
               stateNext  = CLEAR;
               clrCntNext = '0;
            end
         end
         default: begin
            stateNext  = INIT;
            clrCntNext = '0;
         end
      endcase

      errNext = (wr_enA & (~isIdle | ~inRangeA)) |
                (wr_enB & (~isIdle | ~inRangeB)) |
                (swap & ~isIdle) |
                (rd_en & ~inRangeRd);

      // Reads always see the front bank as it stood before this edge
      if (rd_en) begin
         rdDataNext = (inRangeRd && state != INIT) ? mem[front_bank][rd_addr] : '0;
      end

      clrBusyNext = (stateNext != IDLE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= INIT;
         clrCnt     <= '0;
         front_bank <= 1'b0;
         clr_busy   <= 1'b1;
         err        <= 1'b0;
         rd_data    <= '0;
         rd_valid   <= 1'b0;
      end else begin
         state      <= stateNext;
         clrCnt     <= clrCntNext;
         front_bank <= frontNext;
         clr_busy   <= clrBusyNext;
         err        <= errNext;
         rd_data    <= rdDataNext;
         rd_valid   <= rdValidNext;
      end
   end

   // Storage is not reset; port B is applied last so it wins an address collision
   always_ff @(posedge clk) begin
      if (clrBank0) mem[0][clrCnt] <= '0;
      if (clrBank1) mem[1][clrCnt] <= '0;
      if (wrAOk) mem[~front_bank][wr_addrA] <= wr_dataA;
      if (wrBOk) mem[~front_bank][wr_addrB] <= wr_dataB;
   end

endmodule

// File: tb/tb_scanline_pingpong_ram.sv
// Bench for scanline_pingpong_ram: directed vector table, reset/clear corner sequences,
// and randomized traffic compared against a bank-level reference model.
module tb_scanline_pingpong_ram;

   localparam int unsigned DATA_W = 8;
   localparam int unsigned DEPTH  = 20;
   localparam int unsigned ADDR_W = 5;

   logic              clk, rst;
   logic              wr_enA, wr_enB, rd_en, swap;
   logic [ADDR_W-1:0] wr_addrA, wr_addrB, rd_addr;
   logic [DATA_W-1:0] wr_dataA, wr_dataB;
   logic [DATA_W-1:0] rd_data;
   logic              rd_valid, front_bank, clr_busy, err;

   int checks = 0;
   int errors = 0;

   scanline_pingpong_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst),
      .wr_enA(wr_enA), .wr_addrA(wr_addrA), .wr_dataA(wr_dataA),
      .wr_enB(wr_enB), .wr_addrB(wr_addrB), .wr_dataB(wr_dataB),
      .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .rd_valid(rd_valid),
      .swap(swap), .front_bank(front_bank), .clr_busy(clr_busy), .err(err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference model: whole banks, a busy countdown, and the new back bank zeroed at once
   logic [DATA_W-1:0] mMem [2][DEPTH];
   bit                mFront, mInit, mRdValid, mErr;
   logic [DATA_W-1:0] mRdData;
   int                mBusyLeft;

   task automatic modelReset();
      mFront = 0; mInit = 1; mRdValid = 0; mErr = 0; mRdData = '0; mBusyLeft = DEPTH;
      for (int b = 0; b < 2; b++)
         for (int i = 0; i < DEPTH; i++) mMem[b][i] = '0;
   endtask

   task automatic modelStep(input bit wA, input int aA, input logic [7:0] dA,
                            input bit wB, input int aB, input logic [7:0] dB,
                            input bit rd, input int ra, input bit sw);
      bit busyPre = (mBusyLeft > 0);
      int back = mFront ? 0 : 1;
      mErr = (wA && (busyPre || aA >= DEPTH)) || (wB && (busyPre || aB >= DEPTH)) ||
             (sw && busyPre) || (rd && ra >= DEPTH);
      if (rd) begin
         mRdValid = 1;
         mRdData  = (mInit || ra >= DEPTH) ? '0 : mMem[int'(mFront)][ra];
      end else begin
         mRdValid = 0;
      end
      if (!busyPre) begin
         if (wA && aA < DEPTH) mMem[back][aA] = dA;
         if (wB && aB < DEPTH) mMem[back][aB] = dB;
      end
      if (busyPre) begin
         mBusyLeft--;
         if (mBusyLeft == 0) mInit = 0;
      end
      if (sw && !busyPre) begin
         mFront = !mFront;
         for (int i = 0; i < DEPTH; i++) mMem[int'(!mFront)][i] = '0;
         mBusyLeft = DEPTH;
      end
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One clock: drive, step the model with the same inputs, compare just after the edge
   task automatic doCycle(input bit wA, input int aA, input logic [7:0] dA,
                          input bit wB, input int aB, input logic [7:0] dB,
                          input bit rd, input int ra, input bit sw);
      wr_enA = wA; wr_addrA = ADDR_W'(aA); wr_dataA = dA;
      wr_enB = wB; wr_addrB = ADDR_W'(aB); wr_dataB = dB;
      rd_en = rd; rd_addr = ADDR_W'(ra); swap = sw;
      @(posedge clk);
      modelStep(wA, aA, dA, wB, aB, dB, rd, ra, sw);
      #1;
      check("model rd_data", 32'(rd_data), 32'(mRdData));
      check("model rd_valid", 32'(rd_valid), 32'(mRdValid));
      check("model err", 32'(err), 32'(mErr));
      check("model front_bank", 32'(front_bank), 32'(mFront));
      check("model clr_busy", 32'(clr_busy), 32'(mBusyLeft > 0));
   endtask

   task automatic idleCycle();
      doCycle(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0);
   endtask

   task automatic waitIdle();
      for (int k = 0; k < 64 && clr_busy; k++) idleCycle();
      check("wait clr_busy drop", 32'(clr_busy), 32'd0);
   endtask

   // Counts cycles with clr_busy high, starting from the cycle right after release
   task automatic countBusy(input string name);
      int n = 0;
      for (int k = 0; k < 64; k++) begin
         if (!clr_busy) break;
         n++;
         idleCycle();
      end
      check(name, 32'(n), 32'(DEPTH));
   endtask

   typedef struct {
      bit          waitIdle;
      bit          wA; int aA; logic [7:0] dA;
      bit          wB; int aB; logic [7:0] dB;
      bit          rd; int ra;
      bit          sw;
      logic [7:0]  eData;
      bit          eValid, eErr, eFront, eBusy;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(bit w, bit wA, int aA, logic [7:0] dA, bit wB, int aB,
                               logic [7:0] dB, bit rd, int ra, bit sw, logic [7:0] eD,
                               bit eV, bit eE, bit eF, bit eB);
      vec_t v;
      v.waitIdle = w; v.wA = wA; v.aA = aA; v.dA = dA; v.wB = wB; v.aB = aB; v.dB = dB;
      v.rd = rd; v.ra = ra; v.sw = sw;
      v.eData = eD; v.eValid = eV; v.eErr = eE; v.eFront = eF; v.eBusy = eB;
      return v;
   endfunction

   initial begin
      //              w  wA aA dA     wB aB dB     rd ra sw   data  v  e  f  b
      vecs.push_back(mk(0, 1, 3, 8'h5A, 1, 7, 8'hC3, 0, 0, 0, 8'h00, 0, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0, 1, 1));
      vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 1, 3, 0, 8'h5A, 1, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 7, 0, 8'hC3, 1, 0, 1, 0));
      vecs.push_back(mk(0, 1, 5, 8'h11, 1, 5, 8'h22, 0, 0, 0, 8'hC3, 0, 0, 1, 0));
      vecs.push_back(mk(0, 1, 9, 8'h77, 0, 0, 8'h00, 1, 3, 1, 8'h5A, 1, 0, 0, 1));
      vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 1, 5, 0, 8'h22, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 9, 0, 8'h77, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 8'h77, 0, 0, 1, 1));
      vecs.push_back(mk(0, 1, 2, 8'h99, 0, 0, 8'h00, 0, 0, 0, 8'h77, 0, 1, 1, 1));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 8'h77, 0, 1, 1, 1));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 0, 8'h77, 0, 0, 1, 1));
      vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 8'h77, 0, 0, 0, 1));
      vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 1, 9, 0, 8'h00, 1, 0, 0, 0));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 2, 0, 8'h00, 1, 0, 0, 0));
      vecs.push_back(mk(0, 1, 4, 8'h3C, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 0, 0, 0));
      vecs.push_back(mk(0, 1, 20, 8'h55, 0, 0, 8'h00, 0, 0, 0, 8'h00, 0, 1, 0, 0));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1, 8'h00, 0, 0, 1, 1));
      vecs.push_back(mk(1, 0, 0, 8'h00, 0, 0, 8'h00, 1, 4, 0, 8'h3C, 1, 0, 1, 0));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 25, 0, 8'h00, 1, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 8'h00, 1, 31, 8'hEE, 0, 0, 0, 8'h00, 0, 1, 1, 0));
      vecs.push_back(mk(0, 0, 0, 8'h00, 0, 0, 8'h00, 1, 4, 0, 8'h3C, 1, 0, 1, 0));

      rst = 1'b0;
      wr_enA = 0; wr_addrA = '0; wr_dataA = '0;
      wr_enB = 0; wr_addrB = '0; wr_dataB = '0;
      rd_en = 0; rd_addr = '0; swap = 0;
      modelReset();
      repeat (2) @(posedge clk);
      #1;
      check("reset front_bank", 32'(front_bank), 32'd0);
      check("reset rd_data", 32'(rd_data), 32'd0);
      check("reset rd_valid", 32'(rd_valid), 32'd0);
      check("reset err", 32'(err), 32'd0);
      check("reset clr_busy", 32'(clr_busy), 32'd1);

      rst = 1'b1;
      countBusy("init busy cycles");
      for (int a = 0; a < DEPTH; a++) begin
         doCycle(0, 0, 8'h00, 0, 0, 8'h00, 1, a, 0);
         check("post-init rd_data", 32'(rd_data), 32'd0);
         check("post-init rd_valid", 32'(rd_valid), 32'd1);
      end

      foreach (vecs[i]) begin
         if (vecs[i].waitIdle) waitIdle();
         doCycle(vecs[i].wA, vecs[i].aA, vecs[i].dA, vecs[i].wB, vecs[i].aB, vecs[i].dB,
                 vecs[i].rd, vecs[i].ra, vecs[i].sw);
         check($sformatf("vec%0d rd_data", i), 32'(rd_data), 32'(vecs[i].eData));
         check($sformatf("vec%0d rd_valid", i), 32'(rd_valid), 32'(vecs[i].eValid));
         check($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].eErr));
         check($sformatf("vec%0d front_bank", i), 32'(front_bank), 32'(vecs[i].eFront));
         check($sformatf("vec%0d clr_busy", i), 32'(clr_busy), 32'(vecs[i].eBusy));
      end

      // Asynchronous reset in the middle of a CLEAR sequence
      doCycle(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1);
      waitIdle();
      doCycle(1, 1, 8'hA5, 0, 0, 8'h00, 0, 0, 0);
      doCycle(0, 0, 8'h00, 0, 0, 8'h00, 0, 0, 1);
      check("pre-reset front_bank", 32'(front_bank), 32'd1);
      for (int k = 0; k < 9; k++) doCycle(0, 0, 8'h00, 0, 0, 8'h00, 1, 1, 0);
      check("pre-reset rd_data", 32'(rd_data), 32'hA5);
      rst = 1'b0;
      modelReset();
      #1;
      check("midclear front_bank", 32'(front_bank), 32'd0);
      check("midclear rd_data", 32'(rd_data), 32'd0);
      check("midclear rd_valid", 32'(rd_valid), 32'd0);
      check("midclear err", 32'(err), 32'd0);
      check("midclear clr_busy", 32'(clr_busy), 32'd1);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      countBusy("re-init busy cycles");

      // Randomized traffic against the reference model
      for (int n = 0; n < 600; n++) begin
         doCycle(($urandom % 3) == 0, int'($urandom_range(0, 23)), 8'($urandom),
                 ($urandom % 3) == 0, int'($urandom_range(0, 23)), 8'($urandom),
                 ($urandom % 2) == 0, int'($urandom_range(0, 23)),
                 ($urandom % 24) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
